// File: rtl/word_counter_if.sv
// Command / status bundle between the instruction decoder side and the
// word-count stage of the DMA address generator.
interface word_counter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             ld_word;
  logic             reinit;
  logic             cnt_en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] add_cnt_in;
  logic [WIDTH-1:0] word_cnt_out;
  logic [WIDTH-1:0] word_reg_out;
  logic             done;
  logic             busy;

  modport master (
    output data_in, ld_word, reinit, cnt_en, mode, add_cnt_in,
    input  word_cnt_out, word_reg_out, done, busy
  );

  modport slave (
    input  data_in, ld_word, reinit, cnt_en, mode, add_cnt_in,
    output word_cnt_out, word_reg_out, done, busy
  );
endinterface

// File: rtl/word_counter.sv
// Word register / word counter stage of an Am2940-style DMA address
// generator. Holds WR and WC, steps WC on cnt_en and flags terminal count
// according to the 2-bit control-register mode. All outputs registered.
module word_counter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  word_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_TERMINAL = 2'd2
  } state_t;

  localparam logic [1:0] M_DOWN  = 2'b00;
  localparam logic [1:0] M_UPWR  = 2'b01;
  localparam logic [1:0] M_ADDR  = 2'b10;

  state_t           r_state;
  logic [WIDTH-1:0] r_wr;
  logic [WIDTH-1:0] r_wc;
  logic             r_done;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_wr_nxt;
  logic [WIDTH-1:0] w_wc_nxt;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_reload;

  // Candidate step value: mode 00 counts down, every other mode counts up.
  // Wraps naturally modulo 2^WIDTH.
  always_comb begin
    w_step   = (bus.mode == M_DOWN) ? (r_wc - 1'b1) : (r_wc + 1'b1);
    w_reload = (bus.mode == M_DOWN) ? r_wr : '0;
  end

  // Next-state / datapath: ld_word beats reinit beats cnt_en.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr;
    w_wc_nxt    = r_wc;
    if (bus.ld_word) begin
      w_wr_nxt    = bus.data_in;
      w_wc_nxt    = (bus.mode == M_DOWN) ? bus.data_in : '0;
      w_state_nxt = S_ACTIVE;
    end else if (bus.reinit) begin
      // reinit is a no-op in IDLE; it still masks cnt_en (ignored there anyway)
      if (r_state != S_IDLE) begin
        w_wc_nxt    = w_reload;
        w_state_nxt = S_ACTIVE;
      end
    end else if (r_state == S_ACTIVE) begin
      if (bus.cnt_en)
        w_wc_nxt = w_step;
      // Terminal detection only ever looks at a stepped value (or the
      // address compare), so a loaded WR of 0 means a full 2^WIDTH words.
      unique case (bus.mode)
        M_DOWN:  if (bus.cnt_en && (w_step == '0))   w_state_nxt = S_TERMINAL;
        M_UPWR:  if (bus.cnt_en && (w_step == r_wr)) w_state_nxt = S_TERMINAL;
        M_ADDR:  if (bus.add_cnt_in == r_wr)         w_state_nxt = S_TERMINAL;
        default: ;  // mode 11 free-runs
      endcase
    end
  end

  // State, WR, WC and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wr    <= '0;
      r_wc    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
      r_wc    <= w_wc_nxt;
      r_done  <= (w_state_nxt == S_TERMINAL);
      r_busy  <= (w_state_nxt == S_ACTIVE);
    end
  end

  assign bus.word_cnt_out = r_wc;
  assign bus.word_reg_out = r_wr;
  assign bus.done         = r_done;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_word_counter.sv
// Directed bench for word_counter: a vector table for the main command
// flow, plus hand-written loops for wrap, free-run and async reset.
module tb_word_counter;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  word_counter_if #(.WIDTH(W)) bus ();

  word_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         ld;
    logic         ri;
    logic         ce;
    logic [1:0]   mode;
    logic [W-1:0] data;
    logic [W-1:0] add;
    logic [W-1:0] e_wc;
    logic [W-1:0] e_wr;
    logic         e_done;
    logic         e_busy;
  } vec_t;

  localparam int NV = 24;
  vec_t vec [NV];

  task automatic check(input string name, input logic [W-1:0] wc, input logic [W-1:0] wr,
                       input logic dn, input logic bz);
    n_checks++;
    if ({bus.word_cnt_out, bus.word_reg_out, bus.done, bus.busy} !== {wc, wr, dn, bz}) begin
      n_errors++;
      $display("FAIL %s: got wc=%0d wr=%0d done=%0b busy=%0b, want wc=%0d wr=%0d done=%0b busy=%0b",
               name, bus.word_cnt_out, bus.word_reg_out, bus.done, bus.busy, wc, wr, dn, bz);
    end
  endtask

  // Drive one cycle of commands at the falling edge, sample 1 after the rising edge.
  task automatic step(input logic ld, input logic ri, input logic ce, input logic [1:0] mode,
                      input logic [W-1:0] data, input logic [W-1:0] add);
    @(negedge clk);
    bus.ld_word    = ld;
    bus.reinit     = ri;
    bus.cnt_en     = ce;
    bus.mode       = mode;
    bus.data_in    = data;
    bus.add_cnt_in = add;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            ld    ri    ce    mode   data   add     wc     wr    dn    bz
    vec[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'd3, 4'd0,   4'd3,  4'd3, 1'b0, 1'b1};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0,   4'd2,  4'd3, 1'b0, 1'b1};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0,   4'd1,  4'd3, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0,   4'd0,  4'd3, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0,   4'd0,  4'd3, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd0,  4'd3, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 2'b01, 4'd5, 4'd0,   4'd0,  4'd5, 1'b0, 1'b1};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd1,  4'd5, 1'b0, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd2,  4'd5, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd3,  4'd5, 1'b0, 1'b1};
    vec[10] = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd4,  4'd5, 1'b0, 1'b1};
    vec[11] = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd5,  4'd5, 1'b1, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd5,  4'd5, 1'b1, 1'b0};
    vec[13] = '{1'b0, 1'b1, 1'b0, 2'b01, 4'd0, 4'd0,   4'd0,  4'd5, 1'b0, 1'b1};
    vec[14] = '{1'b1, 1'b1, 1'b1, 2'b00, 4'd7, 4'd0,   4'd7,  4'd7, 1'b0, 1'b1};
    vec[15] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0,   4'd7,  4'd7, 1'b0, 1'b1};
    vec[16] = '{1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0,   4'd6,  4'd7, 1'b0, 1'b1};
    vec[17] = '{1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0,   4'd7,  4'd7, 1'b1, 1'b0};
    vec[18] = '{1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0,   4'd7,  4'd7, 1'b0, 1'b1};
    vec[19] = '{1'b1, 1'b0, 1'b0, 2'b10, 4'd9, 4'd0,   4'd0,  4'd9, 1'b0, 1'b1};
    vec[20] = '{1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 4'd7,   4'd1,  4'd9, 1'b0, 1'b1};
    vec[21] = '{1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 4'd8,   4'd2,  4'd9, 1'b0, 1'b1};
    vec[22] = '{1'b0, 1'b0, 1'b0, 2'b10, 4'd0, 4'd9,   4'd2,  4'd9, 1'b1, 1'b0};
    vec[23] = '{1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 4'd9,   4'd2,  4'd9, 1'b1, 1'b0};

    bus.ld_word = 1'b0; bus.reinit = 1'b0; bus.cnt_en = 1'b0;
    bus.mode = 2'b00; bus.data_in = '0; bus.add_cnt_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main command flow from the table.
    for (int i = 0; i < NV; i++) begin
      step(vec[i].ld, vec[i].ri, vec[i].ce, vec[i].mode, vec[i].data, vec[i].add);
      check($sformatf("vec%0d", i), vec[i].e_wc, vec[i].e_wr, vec[i].e_done, vec[i].e_busy);
    end

    // Mode 00, WR=0: full 16-word countdown, terminal only on the 16th step.
    step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
    check("m00_ld0", 4'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
      check($sformatf("m00_wrap%0d", k), 4'((16 - k) % 16), 4'd0, k == 16, k != 16);
    end

    // Mode 01, WR=0: count up 16 steps back to WR.
    step(1'b1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd0);
    check("m01_ld0", 4'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0);
      check($sformatf("m01_wrap%0d", k), 4'(k % 16), 4'd0, k == 16, k != 16);
    end

    // Mode 11: free-run 20 steps, wraps 15 -> 0, never terminal.
    step(1'b1, 1'b0, 1'b0, 2'b11, 4'd2, 4'd2);
    check("m11_ld", 4'd0, 4'd2, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'b11, 4'd0, 4'd2);
      check($sformatf("m11_run%0d", k), 4'(k % 16), 4'd2, 1'b0, 1'b1);
    end

    // Async reset in the middle of a cycle clears outputs before the next edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // reinit and cnt_en in IDLE have no effect.
    step(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    check("idle_reinit", 4'd0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 4'd0);
    check("idle_cnt", 4'd0, 4'd0, 1'b0, 1'b0);

    // Normal operation resumes after reset.
    step(1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 4'd0);
    check("post_rst_ld", 4'd1, 4'd1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
    check("post_rst_term", 4'd0, 4'd1, 1'b1, 1'b0);

    @(negedge clk);
    bus.cnt_en = 1'b0; bus.ld_word = 1'b0; bus.reinit = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
